// File: rtl/bus_arb_pkg.sv
// Shared constants for the datapath bus arbiter: select codes, widths and the FSM state type.
package bus_arb_pkg;

  localparam int SEL_W  = 5;
  localparam int HOLD_W = 4;

  localparam logic [SEL_W-1:0] SEL_NONE   = 5'd0;
  localparam logic [SEL_W-1:0] SEL_R0     = 5'd1;
  localparam logic [SEL_W-1:0] SEL_R1     = 5'd2;
  localparam logic [SEL_W-1:0] SEL_R2     = 5'd3;
  localparam logic [SEL_W-1:0] SEL_R3     = 5'd4;
  localparam logic [SEL_W-1:0] SEL_R4     = 5'd5;
  localparam logic [SEL_W-1:0] SEL_R5     = 5'd6;
  localparam logic [SEL_W-1:0] SEL_R6     = 5'd7;
  localparam logic [SEL_W-1:0] SEL_R7     = 5'd8;
  localparam logic [SEL_W-1:0] SEL_R8     = 5'd9;
  localparam logic [SEL_W-1:0] SEL_R9     = 5'd10;
  localparam logic [SEL_W-1:0] SEL_R10    = 5'd11;
  localparam logic [SEL_W-1:0] SEL_R11    = 5'd12;
  localparam logic [SEL_W-1:0] SEL_R12    = 5'd13;
  localparam logic [SEL_W-1:0] SEL_R13    = 5'd14;
  localparam logic [SEL_W-1:0] SEL_R14    = 5'd15;
  localparam logic [SEL_W-1:0] SEL_R15    = 5'd16;
  localparam logic [SEL_W-1:0] SEL_HI     = 5'd17;
  localparam logic [SEL_W-1:0] SEL_LO     = 5'd18;
  localparam logic [SEL_W-1:0] SEL_ZHI    = 5'd19;
  localparam logic [SEL_W-1:0] SEL_ZLO    = 5'd20;
  localparam logic [SEL_W-1:0] SEL_PC     = 5'd21;
  localparam logic [SEL_W-1:0] SEL_MDR    = 5'd22;
  localparam logic [SEL_W-1:0] SEL_INPORT = 5'd23;
  localparam logic [SEL_W-1:0] SEL_CSIGN  = 5'd24;
  localparam logic [SEL_W-1:0] SEL_Y      = 5'd25;
  localparam logic [SEL_W-1:0] SEL_IR     = 5'd26;
  localparam logic [SEL_W-1:0] SEL_MAR    = 5'd27;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arbState_t;

endpackage

// File: rtl/bus_select_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping, optionally skipping one index.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int N  = 27,
  parameter int IW = 5
) (
  input  logic [N-1:0]  reqVec,
  input  logic [IW-1:0] ptr,
  input  logic          exclEn,
  input  logic [IW-1:0] excl,
  output logic [N-1:0]  winOh,
  output logic [IW-1:0] winIdx,
  output logic          winVld
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0]  cand;
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    cand = reqVec;
    for (int i = 0; i < N; i++) begin
      if (exclEn && (excl == IW'(i))) cand[i] = 1'b0;
    end
  end

  // Rotating right by ptr puts the highest-priority candidate at bit 0.
  assign rot = N'({cand, cand} >> ptr);

  always_comb begin
    winVld = 1'b0;
    off    = '0;
    for (int i = 0; i < N; i++) begin
      if (!winVld && rot[i]) begin
        winVld = 1'b1;
        off    = IW'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    winIdx = IW'(sum);
  end

  always_comb begin
    winOh = '0;
    for (int i = 0; i < N; i++) begin
      winOh[i] = winVld && (winIdx == IW'(i));
    end
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Round-robin bus arbiter with per-grant tenure limit driving the bus mux select; 1-cycle registered latency.
// Requesters hold req until done; BUS_PRIO_EN adds PRIO_MASK sources that win and preempt.
module bus_select_arbiter #(
  parameter int                 NUM_SRC   = 27,
  parameter int                 SEL_W     = 5,
  parameter int                 MAX_HOLD  = 4,
  parameter logic [NUM_SRC-1:0] PRIO_MASK = '0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   select_signal,
  output logic               bus_busy,
  output logic               grant_start
);

  import bus_arb_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_SRC - 1);

  arbState_t          state, nState;
  logic [HOLD_W-1:0]  holdCnt, nHold;
  logic [SEL_W-1:0]   rrPtr, nPtr, nSel;
  logic [NUM_SRC-1:0] nGrant;
  logic               nStart;
  logic               takeWin;

  logic [SEL_W-1:0]   ownerIdx;
  logic               ownerReq;
  logic               exclEn;

  logic [NUM_SRC-1:0] rrOh, winOh;
  logic [SEL_W-1:0]   rrIdx, winIdx;
  logic               rrVld, winVld;
  logic               preempt;

  assign ownerIdx = select_signal - SEL_W'(1);
  assign ownerReq = |(req & grant);
  assign exclEn   = (state == OWN);

  rr_pick #(.N(NUM_SRC), .IW(SEL_W)) uRrPick (
    .reqVec (req),
    .ptr    (rrPtr),
    .exclEn (exclEn),
    .excl   (ownerIdx),
    .winOh  (rrOh),
    .winIdx (rrIdx),
    .winVld (rrVld)
  );

`ifdef BUS_PRIO_EN
  logic [NUM_SRC-1:0] prOh;
  logic [SEL_W-1:0]   prIdx;
  logic               prVld;

  rr_pick #(.N(NUM_SRC), .IW(SEL_W)) uPrioPick (
    .reqVec (req & PRIO_MASK),
    .ptr    (rrPtr),
    .exclEn (exclEn),
    .excl   (ownerIdx),
    .winOh  (prOh),
    .winIdx (prIdx),
    .winVld (prVld)
  );

  // Priority candidates shadow the full round-robin whenever any exist.
  assign winOh   = prVld ? prOh  : rrOh;
  assign winIdx  = prVld ? prIdx : rrIdx;
  assign winVld  = prVld | rrVld;
  assign preempt = prVld && (state == OWN) && !(|(grant & PRIO_MASK));
`else
  logic unusedPrioMask;

  assign unusedPrioMask = ^PRIO_MASK;
  assign winOh   = rrOh;
  assign winIdx  = rrIdx;
  assign winVld  = rrVld;
  assign preempt = 1'b0;
`endif

  always_comb begin
    nState  = state;
    nGrant  = grant;
    nSel    = select_signal;
    nHold   = holdCnt;
    nPtr    = rrPtr;
    nStart  = 1'b0;
    takeWin = 1'b0;

    case (state)
      IDLE: takeWin = winVld;
      OWN: begin
        if (!ownerReq || preempt) begin
          if (winVld) begin
            takeWin = 1'b1;
          end else begin
            nState = IDLE;
            nGrant = '0;
            nSel   = SEL_W'(SEL_NONE);
            nHold  = '0;
          end
        end else if (holdCnt != HOLD_LAST) begin
          nHold = holdCnt + HOLD_W'(1);
        end else if (winVld) begin
          takeWin = 1'b1;
        end
        // Tenure expired with nobody else waiting: keep the bus, hold_cnt stays saturated.
      end
      default: nState = IDLE;
    endcase

    if (takeWin) begin
      nState = OWN;
      nGrant = winOh;
      nSel   = winIdx + SEL_W'(1);
      nStart = 1'b1;
      nHold  = '0;
      nPtr   = (winIdx == LAST_IDX) ? '0 : winIdx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state         <= IDLE;
      holdCnt       <= '0;
      rrPtr         <= '0;
      grant         <= '0;
      select_signal <= '0;
      bus_busy      <= 1'b0;
      grant_start   <= 1'b0;
    end else begin
      state         <= nState;
      holdCnt       <= nHold;
      rrPtr         <= nPtr;
      grant         <= nGrant;
      select_signal <= nSel;
      bus_busy      <= (nState == OWN);
      grant_start   <= nStart;
    end
  end

endmodule
